// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotating-priority search used by the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Upper bound on producers the search function can scan.
  localparam int unsigned MAX_REQ    = 32;
  localparam int unsigned PICK_IDX_W = 5;

  // Returns 1 when some valid bit is set; idx is the first set bit found
  // scanning upward from start and wrapping modulo num.
  function automatic logic rr_pick(input  logic [MAX_REQ-1:0] valid,
                                   input  int unsigned        num,
                                   input  int unsigned        start,
                                   output int unsigned        idx);
    logic        found;
    int unsigned cand;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = (start + k) % num;
      if ((k < num) && !found && valid[PICK_IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational rotating-priority picker: first valid producer at or after start.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    start,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [MAX_REQ-1:0] valid_ext;
  int unsigned        pick_idx;

  always_comb begin
    valid_ext = MAX_REQ'(valid);
    pick_idx  = 0;
    found     = rr_pick(valid_ext, NUM_REQ, 32'(start), pick_idx);
    idx       = ID_W'(pick_idx);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one simple_fifo write port among NUM_REQ producers,
// granting bursts of up to BURST_MAX beats and stalling while the FIFO is full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(BURST_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  // Handshake: a beat moves when req_valid[i] and req_ready[i] are both high
  // at a rising edge; producers hold req_data while valid is high and ready low.
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  output logic                      grant_active,
  output logic [ID_W-1:0]           grant_id,
  output arb_state_e                dbg_state,
  output logic [CNT_W-1:0]          dbg_beat_cnt
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W-1:0]   arb_start;
  logic              owner_valid;
  logic [DATA_W-1:0] owner_data;
  logic              accept;
  logic              release_grant;

  // last_grant always equals the current owner while granted, so one picker
  // serves both the idle path and the same-cycle handoff path.
  assign arb_start = (last_grant_q == ID_W'(NUM_REQ - 1)) ? '0 : last_grant_q + 1'b1;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid (req_valid),
    .start (arb_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    req_ready     = '0;
    fifo_wr_en    = 1'b0;
    fifo_din      = '0;
    accept        = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d      = ARB_GRANT;
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
          beat_cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id_q == ID_W'(i)) begin
            req_ready[i] = !fifo_full;
          end
        end
        accept     = owner_valid && !fifo_full;
        fifo_wr_en = accept;
        fifo_din   = owner_data;
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        release_grant = (accept && (beat_cnt_q == CNT_W'(BURST_MAX - 1))) || !owner_valid;
        if (release_grant) begin
          beat_cnt_d = '0;
          if (pick_found) begin
            grant_id_d   = pick_idx;
            last_grant_d = pick_idx;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign grant_active = (state_q == ARB_GRANT);
  assign grant_id     = grant_id_q;
  assign dbg_state    = state_q;
  assign dbg_beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues drive the handshake, a monitor
// checks each FIFO write against a queue of hand-ordered expected {id, data} beats.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int BURST_MAX = 4;
  localparam int ID_W      = 2;
  localparam int CNT_W     = 3;
  localparam int EW        = ID_W + DATA_W;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_din;
  logic                      grant_active;
  logic [ID_W-1:0]           grant_id;
  arb_state_e                dbg_state;
  logic [CNT_W-1:0]          dbg_beat_cnt;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .dbg_state    (dbg_state),
    .dbg_beat_cnt (dbg_beat_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] pq[NUM_REQ][$];
  int                errors = 0;
  int                checks = 0;
  int                full_from = 0;
  int                full_to = 0;
  int                stall_beat_exp = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [DATA_W-1:0] d);
    exp_q.push_back({ID_W'(id), d});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver ----------------
  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (pq[i].size() != 0);
      req_data[i*DATA_W +: DATA_W] = (pq[i].size() != 0) ? pq[i][0] : '0;
    end
  endtask

  // Runs cycles from posedge+1 to posedge+1; pops accepted beats from producer queues.
  task automatic run(input int max_cyc, input bit drain, output int ncyc, output int idle_cnt);
    logic [NUM_REQ-1:0] acc;
    ncyc = 0;
    idle_cnt = 0;
    while (ncyc < max_cyc && !(drain && all_empty())) begin
      fifo_full = (ncyc >= full_from) && (ncyc < full_to);
      drive();
      @(negedge clk);
      acc = req_valid & req_ready;
      if (ncyc > 0 && !grant_active) idle_cnt++;
      if (fifo_full) begin
        check("stall_ready", 32'(req_ready), 32'd0);
        check("stall_grant_active", 32'(grant_active), 32'd1);
        check("stall_grant_id", 32'(grant_id), 32'd0);
        check("stall_beat_cnt", 32'(dbg_beat_cnt), 32'(stall_beat_exp));
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) void'(pq[i].pop_front());
      ncyc++;
    end
    fifo_full = 1'b0;
    drive();
    if (drain && !all_empty()) begin
      errors++;
      checks++;
      $display("FAIL run_timeout: producers not drained after %0d cycles", max_cyc);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    exp_q.delete();
    full_from = 0;
    full_to = 0;
    fifo_full = 1'b0;
    rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_din", 32'(fifo_din), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
    check("rst_beat_cnt", 32'(dbg_beat_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      logic [EW-1:0] e;
      checks++;
      if (fifo_full) begin
        errors++;
        $display("FAIL write_while_full: wr_en=1 with fifo_full=1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_beat: got id=%0d data=%0h, expected no write", grant_id, fifo_din);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, fifo_din} !== e) begin
          errors++;
          $display("FAIL write_beat: got id=%0d data=%0h, expected id=%0d data=%0h",
                   grant_id, fifo_din, e[EW-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    int idle;
    rst = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data = '0;

    // 1: single producer, 6 beats, burst boundary re-grants itself with no bubble
    do_reset();
    for (int k = 0; k < 6; k++) begin
      pq[0].push_back(DATA_W'(8'hA0 + k));
      push_exp(0, DATA_W'(8'hA0 + k));
    end
    run(100, 1'b1, n, idle);
    check("t1_cycles", 32'(n), 32'd7);
    check("t1_idle", 32'(idle), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // 2: all four producers, 2 beats each, rotating 0,1,2,3
    do_reset();
    for (int p = 0; p < NUM_REQ; p++) begin
      for (int k = 0; k < 2; k++) begin
        pq[p].push_back(DATA_W'(8'h10 * (p + 1) + k));
        push_exp(p, DATA_W'(8'h10 * (p + 1) + k));
      end
    end
    run(100, 1'b1, n, idle);
    check("t2_cycles", 32'(n), 32'd12);
    check("t2_idle", 32'(idle), 32'd0);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: producer 1 bursts 4, producer 2 gets its 2, producer 1 finishes
    do_reset();
    for (int k = 0; k < 6; k++) pq[1].push_back(DATA_W'(8'h50 + k));
    for (int k = 0; k < 2; k++) pq[2].push_back(DATA_W'(8'h60 + k));
    for (int k = 0; k < 4; k++) push_exp(1, DATA_W'(8'h50 + k));
    push_exp(2, 8'h60);
    push_exp(2, 8'h61);
    push_exp(1, 8'h54);
    push_exp(1, 8'h55);
    run(100, 1'b1, n, idle);
    check("t3_cycles", 32'(n), 32'd10);
    check("t3_idle", 32'(idle), 32'd0);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: FIFO full for 3 cycles after two beats of producer 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pq[0].push_back(DATA_W'(8'h70 + k));
      push_exp(0, DATA_W'(8'h70 + k));
    end
    full_from = 3;
    full_to = 6;
    stall_beat_exp = 2;
    run(100, 1'b1, n, idle);
    full_from = 0;
    full_to = 0;
    check("t4_cycles", 32'(n), 32'd8);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // 5: owner drops valid after one beat, producer 3 takes over immediately
    do_reset();
    pq[0].push_back(8'h80);
    pq[3].push_back(8'h90);
    pq[3].push_back(8'h91);
    push_exp(0, 8'h80);
    push_exp(3, 8'h90);
    push_exp(3, 8'h91);
    run(100, 1'b1, n, idle);
    check("t5_cycles", 32'(n), 32'd5);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset mid-burst of producer 2, then producer 0 wins first
    do_reset();
    for (int k = 0; k < 4; k++) pq[2].push_back(DATA_W'(8'hC0 + k));
    for (int k = 0; k < 3; k++) push_exp(2, DATA_W'(8'hC0 + k));
    run(3, 1'b0, n, idle);
    rst = 1'b1;
    run(1, 1'b0, n, idle);
    @(negedge clk);
    check("t6_grant_active", 32'(grant_active), 32'd0);
    check("t6_grant_id", 32'(grant_id), 32'd0);
    check("t6_req_ready", 32'(req_ready), 32'd0);
    check("t6_wr_en", 32'(fifo_wr_en), 32'd0);
    check("t6_din", 32'(fifo_din), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ARB_IDLE));
    check("t6_beat_cnt", 32'(dbg_beat_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    pq[0].push_back(8'hB0);
    push_exp(0, 8'hB0);
    push_exp(2, 8'hC3);
    run(100, 1'b1, n, idle);
    check("t6_cycles", 32'(n), 32'd4);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
